score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 130 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Two-player BCD score keeper: edge-detected up/down requests, saturating 00..99,
// win detection (score >= WIN_SCORE with lead >= WIN_MARGIN) and undo out of GAME_OVER.
module score_keeper #(
  parameter int unsigned WIN_SCORE  = 11,
  parameter int unsigned WIN_MARGIN = 2
) (
  input  logic       clk_1khz,
  input  logic       rst_ni,
  input  logic       up_a_i,
  input  logic       down_a_i,
  input  logic       up_b_i,
  input  logic       down_b_i,
  input  logic       clear_i,
  output logic [7:0] score_a_o,
  output logic [7:0] score_b_o,
  output logic       game_over_o,
  output logic [1:0] winner_o,
  output logic       changed_o
);

  typedef enum logic {PLAYING, GAME_OVER} state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [7:0] WIN_S    = 8'(WIN_SCORE);
  localparam logic [7:0] WIN_M    = 8'(WIN_MARGIN);

  state_e     state_q, state_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic       changed_q, changed_d;
  logic       up_a_q, down_a_q, up_b_q, down_b_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)         return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)         return v;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Opposing up and down events cancel; saturation leaves the value unchanged.
  function automatic logic [7:0] score_step(input logic [7:0] v, input logic up, input logic dn);
    if (up && !dn)      return bcd_inc(v);
    else if (dn && !up) return bcd_dec(v);
    else                return v;
  endfunction

  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
  endfunction

  logic       ev_up_a, ev_dn_a, ev_up_b, ev_dn_b, playing;
  logic [7:0] bin_a, bin_b, nxt_a, nxt_b;
  logic       win_a, win_b;

  always_comb begin
    ev_up_a = up_a_i   & ~up_a_q;
    ev_dn_a = down_a_i & ~down_a_q;
    ev_up_b = up_b_i   & ~up_b_q;
    ev_dn_b = down_b_i & ~down_b_q;
    playing = (state_q == PLAYING);

    bin_a = bcd2bin(score_a_q);
    bin_b = bcd2bin(score_b_q);
    win_a = (bin_a >= WIN_S) && (bin_a >= bin_b + WIN_M);
    win_b = (bin_b >= WIN_S) && (bin_b >= bin_a + WIN_M);

    nxt_a = score_step(score_a_q, ev_up_a & playing, ev_dn_a);
    nxt_b = score_step(score_b_q, ev_up_b & playing, ev_dn_b);

    state_d   = state_q;
    winner_d  = WIN_NONE;
    score_a_d = nxt_a;
    score_b_d = nxt_b;
    changed_d = (nxt_a != score_a_q) || (nxt_b != score_b_q);

    // The win condition is evaluated on the registered scores, so game over trails the score by a cycle.
    case (state_q)
      PLAYING:   if (win_a || win_b) state_d = GAME_OVER;
      GAME_OVER: if (!(win_a || win_b)) state_d = PLAYING;
      default:   state_d = PLAYING;
    endcase
    if (state_d == GAME_OVER) winner_d = win_a ? WIN_A : WIN_B;

    if (clear_i) begin
      state_d   = PLAYING;
      winner_d  = WIN_NONE;
      score_a_d = 8'h00;
      score_b_d = 8'h00;
      changed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= PLAYING;
      winner_q  <= WIN_NONE;
      score_a_q <= 8'h00;
      score_b_q <= 8'h00;
      changed_q <= 1'b0;
      up_a_q    <= 1'b0;
      down_a_q  <= 1'b0;
      up_b_q    <= 1'b0;
      down_b_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      changed_q <= changed_d;
      up_a_q    <= up_a_i;
      down_a_q  <= down_a_i;
      up_b_q    <= up_b_i;
      down_b_q  <= down_b_i;
    end
  end

  assign score_a_o   = score_a_q;
  assign score_b_o   = score_b_q;
  assign game_over_o = (state_q == GAME_OVER);
  assign winner_o    = winner_q;
  assign changed_o   = changed_q;

endmodule
